// File: rtl/sync_down_counter.sv
// Synchronous loadable down counter with registered terminal-count pulse and busy flag.
// Define SYNC_DOWN_COUNTER_AUTO_RELOAD_EN for periodic countdown (reload instead of DONE).
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_busy;

  // Priority on each edge: clear, then load, then enabled count, then hold.
  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else if (load) begin
      r_q      <= load_val;
      r_reload <= load_val;
      if (load_val != '0) begin
        r_state <= COUNT;
        r_tc    <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        r_state <= DONE;
        r_tc    <= 1'b1;
        r_busy  <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
      case (r_state)
        COUNT: begin
          if (en) begin
            if (r_q > WIDTH'(1)) begin
              r_q <= r_q - WIDTH'(1);
            end else if (r_q == WIDTH'(1)) begin
              r_q  <= '0;
              r_tc <= 1'b1;
`ifndef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
              r_state <= DONE;
              r_busy  <= 1'b0;
`endif
            end else begin
              // Sitting at zero in COUNT only happens in periodic mode.
              r_q  <= r_reload;
              r_tc <= (r_reload == '0);
            end
          end
        end
        IDLE, DONE: begin
          r_q <= r_q;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;
  assign tc   = r_tc;
  assign busy = r_busy;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed scoreboard bench for sync_down_counter; expectations queued at drive time.
// Follows SYNC_DOWN_COUNTER_AUTO_RELOAD_EN to select the one-shot or periodic section.
module tb_sync_down_counter;

  logic       clk;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       tc;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sbQ[$];

  sync_down_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .q        (q),
    .qbar     (qbar),
    .tc       (tc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs away from the rising edge and queue the result expected after it.
  task automatic applyStimulus(input logic c, input logic l, input logic [3:0] lv,
                               input logic e, input logic [3:0] eq, input logic etc,
                               input logic eb, input string tag);
    exp_t x;
    @(negedge clk);
    clear    = c;
    load     = l;
    load_val = lv;
    en       = e;
    x.q    = eq;
    x.tc   = etc;
    x.busy = eb;
    x.tag  = tag;
    sbQ.push_back(x);
  endtask

  // Sample just after the rising edge and compare against the oldest expectation.
  task automatic checkOutput();
    exp_t x;
    logic [3:0] expQbar;
    @(posedge clk);
    #1;
    checks++;
    assert (sbQ.size() > 0) else begin
      failures++;
      $error("[TB] FAIL sb_empty observed=0 expected=1");
    end
    if (sbQ.size() > 0) begin
      x = sbQ.pop_front();
      expQbar = ~x.q;
      checks++;
      assert (q === x.q) else begin
        failures++;
        $error("[TB] FAIL %s.q observed=%0d expected=%0d", x.tag, q, x.q);
      end
      checks++;
      assert (qbar === expQbar) else begin
        failures++;
        $error("[TB] FAIL %s.qbar observed=%h expected=%h", x.tag, qbar, expQbar);
      end
      checks++;
      assert (tc === x.tc) else begin
        failures++;
        $error("[TB] FAIL %s.tc observed=%b expected=%b", x.tag, tc, x.tc);
      end
      checks++;
      assert (busy === x.busy) else begin
        failures++;
        $error("[TB] FAIL %s.busy observed=%b expected=%b", x.tag, busy, x.busy);
      end
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [3:0] lv, input logic e,
                      input logic [3:0] eq, input logic etc, input logic eb, input string tag);
    applyStimulus(c, l, lv, e, eq, etc, eb, tag);
    checkOutput();
  endtask

  initial begin
    clear    = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    en       = 1'b0;

    // Reset overrides a simultaneous load and enable.
    step(0, 1, 4'hF, 1, 4'd0, 0, 0, "reset0");
    step(0, 1, 4'hF, 1, 4'd0, 0, 0, "reset1");
    step(1, 0, 4'h0, 1, 4'd0, 0, 0, "idle_en_ignored");

`ifndef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    // One-shot: 3,2,1,0 then parked in DONE.
    step(1, 1, 4'd3, 1, 4'd3, 0, 1, "os_load3");
    step(1, 0, 4'd0, 1, 4'd2, 0, 1, "os_q2");
    step(1, 0, 4'd0, 1, 4'd1, 0, 1, "os_q1");
    step(1, 0, 4'd0, 1, 4'd0, 1, 0, "os_q0");
    for (int i = 0; i < 5; i++) step(1, 0, 4'd0, 1, 4'd0, 0, 0, "os_done_hold");
`else
    // Periodic: 2,1,0 repeating with tc on each zero.
    step(1, 1, 4'd2, 1, 4'd2, 0, 1, "ar_load2");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'd0, 1, 4'd1, 0, 1, "ar_q1");
      step(1, 0, 4'd0, 1, 4'd0, 1, 1, "ar_q0");
      if (i < 2) step(1, 0, 4'd0, 1, 4'd2, 0, 1, "ar_q2");
    end
`endif

    // Enable gaps then a zero load.
    step(1, 1, 4'd5, 0, 4'd5, 0, 1, "gap_load5");
    step(1, 0, 4'd0, 1, 4'd4, 0, 1, "gap_en1a");
    step(1, 0, 4'd0, 0, 4'd4, 0, 1, "gap_en0a");
    step(1, 0, 4'd0, 1, 4'd3, 0, 1, "gap_en1b");
    step(1, 0, 4'd0, 0, 4'd3, 0, 1, "gap_en0b");
    step(1, 1, 4'd0, 0, 4'd0, 1, 0, "zero_load");
    step(1, 0, 4'd0, 1, 4'd0, 0, 0, "zero_done");

    // Load wins over the terminal decrement.
    step(1, 1, 4'd2, 1, 4'd2, 0, 1, "pri_load2");
    step(1, 0, 4'd0, 1, 4'd1, 0, 1, "pri_q1");
    step(1, 1, 4'd9, 1, 4'd9, 0, 1, "pri_load_wins");
    for (int i = 8; i >= 1; i--) step(1, 0, 4'd0, 1, 4'(i), 0, 1, "pri_count");
    step(0, 1, 4'd9, 1, 4'd0, 0, 0, "pri_clear_wins");
    step(1, 0, 4'd0, 1, 4'd0, 0, 0, "pri_idle");

    // Mid-count reset.
    step(1, 1, 4'd12, 0, 4'd12, 0, 1, "mid_load12");
    for (int i = 11; i >= 7; i--) step(1, 0, 4'd0, 1, 4'(i), 0, 1, "mid_count");
    step(0, 0, 4'd0, 1, 4'd0, 0, 0, "mid_clear");
    for (int i = 0; i < 3; i++) step(1, 0, 4'd0, 1, 4'd0, 0, 0, "mid_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
Synchronous, fully clocked, loadable down counter with a registered terminal-count pulse. It complements the existing ripple up counter by counting in the opposite direction. It is the countdown/timer element for delay and timeout generation elsewhere in the design. All state changes on one clock edge, so there is no ripple skew between output bits.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.

Ports:
clk       input   1      system clock; all state updates on rising edge.
clear     input   1      synchronous active-low reset, sampled on rising clk.
load      input   1      load request; q <= load_val on next edge.
load_val  input   WIDTH  start/reload value.
en        input   1      count enable; one decrement per enabled edge.
q         output  WIDTH  current count.
qbar      output  WIDTH  bitwise complement of q, always ~q.
tc        output  1      terminal-count pulse, registered.
busy      output  1      high while in COUNT state.

Interface decision: one clock (clk); reset is synchronous and active-low (clear). There is no asynchronous path.

Behaviour:
- Reset: clear==0 at a rising clk edge gives q=0, qbar=all ones, tc=0, busy=0, state=IDLE, reload_reg=0. clear overrides load and en in every state, including mid-count.
- State machine: IDLE, COUNT, DONE. Encoding is free. busy is asserted only in COUNT.
- Priority per edge: clear, then load, then en, then hold.
- Load (any state):
  - Sets q<=load_val and reload_reg<=load_val.
  - If load_val!=0: next state is COUNT and tc<=0.
  - If load_val==0: next state is DONE and tc<=1 for one cycle.
- IDLE:
  - Without load, q holds and tc=0.
  - en is ignored.
- COUNT, en==0: q holds and tc<=0.
- COUNT, en==1 and q>1: q<=q-1 and tc<=0.
- COUNT, en==1 and q==1:
  - q<=0 and tc<=1.
  - Next state is DONE (without macro) or stays COUNT (with macro, see Optional Feature).
- DONE:
  - q holds at 0 and tc<=0; tc is high only in the first DONE cycle.
  - en is ignored.
  - Exit is via load or clear only.
- tc timing: tc is registered and is high in exactly the cycle where q first shows 0 after a countdown or zero-load.
  - Latency: from a load of N (N>0) with en held high, tc rises N edges after the load edge.
- Load coinciding with the terminal decrement: load wins, q<=load_val, and tc stays 0.
- Arithmetic: q is an unsigned WIDTH-bit value. The counter never decrements below 0, so there is no wrap to all ones in the non-reload mode.
- qbar is combinational ~q, or registered in lock-step with q. Either way it must equal ~q in every cycle.

Optional Feature:
Macro: SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
- Defined (periodic countdown):
  - COUNT never exits to DONE.
  - In COUNT with en==1 and q==0: q<=reload_reg and tc<=0.
  - The count sequence is N, N-1, ..., 1, 0, N, ..., with period N+1 enabled edges. tc is high for one cycle each time q becomes 0.
  - If reload_reg==0, q stays 0 and tc is high on every enabled edge.
  - busy stays high until clear, or until a load of 0.
- Not defined: one-shot behaviour as specified above (COUNT -> DONE at zero).

Test Plan:
- Reset: clear=0 for 2 edges with load=1, load_val=4'hF -> q=0, qbar=4'hF, tc=0, busy=0.
- One-shot count: load 4'd3, then en=1 -> q sequence 3,2,1,0, tc=1 only in the q=0 cycle, busy falls with entry to DONE, q stays 0 after 5 more en edges.
- Enable gaps and zero load: load 5, en toggled 1,0,1,0 -> q sequence 5,4,4,3,3 with tc=0; then load 0 -> q=0, tc=1 for one cycle, state DONE.
- Priority: q==1 with en=1 and load=1, load_val=9 -> q=9, tc=0, busy=1. Repeat with clear=0 on the same edge -> q=0, busy=0.
- Mid-count reset: load 4'd12, count to 7, then clear=0 for one edge -> q=0, tc=0, IDLE; en then has no effect.
- With SYNC_DOWN_COUNTER_AUTO_RELOAD_EN defined: load 2, en=1 for 9 edges -> q sequence 2,1,0,2,1,0,2,1,0, tc high on each 0, busy constant 1.
